// File: rtl/mips_bus_pkg.sv
// Shared bus definitions for the memory-port arbiter: FSM encoding and
// owner-select values.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  // Wide enough for the largest allowed MAX_D_STREAK (15).
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mux2_1.sv
// Generic two-input multiplexer. The data path is WIDTH+1 bits wide.
module mux2_1 #(
  parameter int WIDTH = 31
) (
  input  logic [WIDTH:0] d0,
  input  logic [WIDTH:0] d1,
  input  logic           sel,
  output logic [WIDTH:0] y
);

  // Select d1 when sel is high, otherwise d0.
  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D).
// D has priority, but I is forced through after MAX_D_STREAK back-to-back D
// grants. A watchdog ends an access with bus_err if mem_ack never arrives.
module mem_port_arbiter
  import mips_bus_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_sel,
  output logic          bus_err
);

  // The watchdog counts BUSY cycles already spent; it fires on the last one.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [DW-1:0] ZERO_DATA = '0;

  state_t              state, state_nxt;
  logic [STREAK_W-1:0] streak;
  logic [TW-1:0]       tcnt;
  logic                grant_d, grant_i, done_ok, done_to;
  logic [AW-1:0]       addr_nxt;
  logic [DW-1:0]       wdata_nxt;

  // Arbitration and next-state decode.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (d_req && !(i_req && streak == STREAK_MAX)) begin
          grant_d   = 1'b1;
          state_nxt = ST_BUSY;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          done_ok   = 1'b1;
          state_nxt = ST_RESP;
        end else if (TIMEOUT != 0 && tcnt == TO_LAST) begin
          done_to   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Owner address / write data to be captured on a grant.
  mux2_1 #(.WIDTH(AW-1)) u_addr_mux (
    .d0  (i_addr),
    .d1  (d_addr),
    .sel (grant_d),
    .y   (addr_nxt)
  );

  mux2_1 #(.WIDTH(DW-1)) u_wdata_mux (
    .d0  (ZERO_DATA),
    .d1  (d_wdata),
    .sel (grant_d),
    .y   (wdata_nxt)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Registered memory-port outputs, acks, read data and bus error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= SEL_I;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      if (grant_d || grant_i) begin
        mem_req   <= 1'b1;
        mem_sel   <= grant_d ? SEL_D : SEL_I;
        mem_we    <= grant_d & d_we;
        mem_addr  <= addr_nxt;
        mem_wdata <= wdata_nxt;
      end
      if (done_ok || done_to) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        bus_err <= done_to;
        if (mem_sel == SEL_D) begin
          d_ack   <= 1'b1;
          d_rdata <= done_ok ? mem_rdata : ZERO_DATA;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= done_ok ? mem_rdata : ZERO_DATA;
        end
      end
    end
  end

  // Consecutive-D-grant counter seen by a waiting I; only moves in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (state == ST_IDLE) begin
      if (grant_i || !i_req)
        streak <= '0;
      else if (grant_d && streak != STREAK_MAX)
        streak <= streak + 1'b1;
    end
  end

  // Watchdog: counts cycles spent in BUSY, cleared everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tcnt <= '0;
    else if (state == ST_BUSY) tcnt <= tcnt + 1'b1;
    else                     tcnt <= '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized phase, checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TO   = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          i_ack, d_ack, mem_req, mem_we, mem_sel, bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_sel   (mem_sel),
    .bus_err   (bus_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: D grants in a row while I waited, and last data per owner.
  int            d_run = 0;
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = $urandom;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = $urandom;
    d_wdata = $urandom;
  endtask

  // Wait (bounded) for mem_req to rise.
  task automatic wait_grant(output bit ok, output int waited);
    waited = 0;
    while (mem_req !== 1'b1 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    ok = (mem_req === 1'b1);
    check("grant_seen", 64'(mem_req), 64'd1);
  endtask

  // Compare the captured access against the model's choice and update the model.
  task automatic check_grant(output bit owner_d, output logic [AW-1:0] exp_addr);
    owner_d  = d_req && !(i_req && d_run == MAXS);
    exp_addr = owner_d ? d_addr : i_addr;
    check("mem_sel",   64'(mem_sel),   64'(owner_d));
    check("mem_addr",  64'(mem_addr),  64'(exp_addr));
    check("mem_we",    64'(mem_we),    64'(owner_d && d_we));
    check("mem_wdata", 64'(mem_wdata), owner_d ? 64'(d_wdata) : 64'd0);
    if (!i_req || !owner_d) d_run = 0;
    else if (d_run < MAXS)  d_run++;
  endtask

  // Checks in the ack cycle.
  task automatic finish_ack(input bit owner_d, input logic [DW-1:0] data, input bit err);
    if (owner_d) exp_d_rdata = data;
    else         exp_i_rdata = data;
    check("i_ack",        64'(i_ack),   64'(!owner_d));
    check("d_ack",        64'(d_ack),   64'(owner_d));
    check("i_rdata",      64'(i_rdata), 64'(exp_i_rdata));
    check("d_rdata",      64'(d_rdata), 64'(exp_d_rdata));
    check("bus_err",      64'(bus_err), 64'(err));
    check("mem_req_resp", 64'(mem_req), 64'd0);
    check("mem_we_resp",  64'(mem_we),  64'd0);
  endtask

  // One complete access: grant, lat cycles of wait, mem_ack with data, ack check.
  task automatic serve(input int lat, input logic [DW-1:0] data, output bit owner_d, output int waited);
    bit            ok;
    logic [AW-1:0] ea;
    wait_grant(ok, waited);
    if (!ok) begin
      owner_d = 1'b0;
      return;
    end
    check_grant(owner_d, ea);
    repeat (lat) @(negedge clk);
    if (lat > 0) begin
      check("hold_req",  64'(mem_req),  64'd1);
      check("hold_addr", 64'(mem_addr), 64'(ea));
    end
    mem_rdata = data;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    finish_ack(owner_d, data, 1'b0);
  endtask

  initial begin
    bit            od, ok;
    int            w, n;
    logic [9:0]    pat;
    logic [AW-1:0] ea;

    i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_mem_req",   64'(mem_req),   64'd0);
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_sel",   64'(mem_sel),   64'd0);
    check("rst_i_ack",     64'(i_ack),     64'd0);
    check("rst_d_ack",     64'(d_ack),     64'd0);
    check("rst_i_rdata",   64'(i_rdata),   64'd0);
    check("rst_d_rdata",   64'(d_rdata),   64'd0);
    check("rst_bus_err",   64'(bus_err),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch with minimum latency.
    i_req  = 1'b1;
    i_addr = 32'h0040_0000;
    serve(0, 32'h8C01_0004, od, w);
    check("fetch_latency", 64'(w), 64'd1);
    check("fetch_rdata", 64'(i_rdata), 64'h8C01_0004);
    i_req = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", 64'(i_ack), 64'd0);

    // Simultaneous requests: D store first, then I.
    new_i();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF;
    serve(1, $urandom, od, w);
    check("both_first_sel", 64'(mem_sel), 64'd1);
    d_req = 1'b0;
    serve(0, $urandom, od, w);
    check("both_second_sel", 64'(mem_sel), 64'd0);
    i_req = 1'b0;

    // Both held continuously: starvation guard.
    new_i(); new_d();
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      serve($urandom_range(0, 2), $urandom, od, w);
      pat = {pat[8:0], mem_sel};
      if (od) new_d(); else new_i();
    end
    check("streak_pattern", 64'(pat), 64'(10'b1111011110));
    i_req = 1'b0; d_req = 1'b0;

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      if (!i_req && !d_req) begin
        case ($urandom_range(0, 2))
          0:       new_i();
          1:       new_d();
          default: begin new_i(); new_d(); end
        endcase
      end
      serve($urandom_range(0, 3), $urandom, od, w);
      if ($urandom_range(0, 1) == 1) begin
        if (od) new_d(); else new_i();
      end else begin
        if (od) d_req = 1'b0; else i_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Watchdog: memory never answers.
    new_d();
    wait_grant(ok, w);
    check_grant(od, ea);
    n = 0;
    while (d_ack !== 1'b1 && n < 100) begin
      if (mem_req === 1'b1) n++;
      @(negedge clk);
    end
    check("timeout_cycles", 64'(n), 64'(TO));
    d_req = 1'b0;
    finish_ack(1'b1, '0, 1'b1);
    @(negedge clk);
    check("post_to_d_ack",   64'(d_ack),   64'd0);
    check("post_to_bus_err", 64'(bus_err), 64'd0);
    check("post_to_mem_req", 64'(mem_req), 64'd0);

    // Spurious mem_ack while idle.
    mem_ack = 1'b1; mem_rdata = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_ack_i",   64'(i_ack),   64'd0);
      check("idle_ack_d",   64'(d_ack),   64'd0);
      check("idle_mem_req", 64'(mem_req), 64'd0);
    end
    mem_ack = 1'b0;
    new_i();
    serve(0, $urandom, od, w);
    check("idle_then_latency", 64'(w), 64'd1);
    i_req = 1'b0;

    // Reset in the middle of an access.
    new_i(); new_d();
    for (int k = 0; k < 2; k++) begin
      serve(0, $urandom, od, w);
      if (od) new_d(); else new_i();
    end
    wait_grant(ok, w);
    check_grant(od, ea);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_mem_req", 64'(mem_req), 64'd0);
    check("async_mem_sel", 64'(mem_sel), 64'd0);
    check("async_i_rdata", 64'(i_rdata), 64'd0);
    check("async_d_rdata", 64'(d_rdata), 64'd0);
    d_run = 0; exp_i_rdata = '0; exp_d_rdata = '0;
    i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_i_ack",   64'(i_ack),   64'd0);
      check("post_rst_d_ack",   64'(d_ack),   64'd0);
      check("post_rst_mem_req", 64'(mem_req), 64'd0);
    end
    new_i(); new_d();
    pat = '0;
    for (int k = 0; k < 5; k++) begin
      serve(0, $urandom, od, w);
      pat = {pat[8:0], mem_sel};
      if (od) new_d(); else new_i();
    end
    check("post_rst_streak", 64'(pat[4:0]), 64'(5'b11110));
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Serialises one access at a time and drives the port address/data mux select.
- Returns read data and a one-cycle ack to the granted requester.
- Sits between the IF/MEM pipeline stages and the unified memory; prioritises D with a starvation guard for I, and includes a bus-timeout watchdog.

Parameters:
- AW, 32, address width in bits
- DW, 32, data width in bits
- MAX_D_STREAK, 4, consecutive D grants allowed while i_req is pending before I is forced (range 1..15)
- TIMEOUT, 64, cycles to wait for mem_ack before error; 0 disables the watchdog

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_req  input  1  fetch request; held until i_ack
- i_addr  input  AW  fetch address; stable while i_req=1
- i_rdata  output  DW  fetch data; valid when i_ack=1
- i_ack  output  1  one-cycle completion pulse to I
- d_req  input  1  data request; held until d_ack
- d_we  input  1  1=write, 0=read
- d_addr  input  AW  data address
- d_wdata  input  DW  store data
- d_rdata  output  DW  load data; valid when d_ack=1
- d_ack  output  1  one-cycle completion pulse to D
- mem_req  output  1  memory request; held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data; valid with mem_ack
- mem_ack  input  1  memory completion pulse
- mem_sel  output  1  owner select: 0=I, 1=D
- bus_err  output  1  one-cycle pulse, coincident with the ack of a timed-out access

Behaviour:
- Reset (asynchronous, any state): state=IDLE, and all of the following clear to 0:
  - outputs: mem_req, mem_we, mem_addr, mem_wdata, mem_sel, i_ack, d_ack, i_rdata, d_rdata, bus_err
  - internal: streak counter, timeout counter
  - mem_req drops immediately on rst_n fall; an in-flight access is abandoned, and no ack is issued after reset releases.
- States: IDLE, BUSY (mem_req=1), RESP (ack cycle). All outputs are registered.
- IDLE arbitration, sampled at the clock edge:
  - d_req & !(i_req & streak==MAX_D_STREAK) -> grant D.
  - Otherwise i_req -> grant I.
  - No request -> stay in IDLE.
- On grant, go to BUSY and capture into registers:
  - mem_sel = owner
  - mem_addr = owner address
  - mem_we = d_we for D, 0 for I
  - mem_wdata = d_wdata for D, 0 for I
  - mem_req = 1
- Streak counter:
  - Increments on a D grant while i_req=1, saturating at MAX_D_STREAK.
  - Clears on an I grant, or whenever i_req=0 in IDLE.
- BUSY:
  - Hold mem_* stable.
  - mem_ack=1 -> RESP: mem_req=0, mem_we=0, owner rdata <= mem_rdata, owner ack=1.
  - Timeout counter increments each BUSY cycle. When it reaches TIMEOUT with no mem_ack (and TIMEOUT!=0) -> RESP with mem_req=0, owner rdata=0, owner ack=1, bus_err=1.
- RESP: lasts exactly one cycle; ack and bus_err return to 0, then IDLE. No arbitration in RESP.
- Latency and throughput:
  - req sampled at edge N -> mem_req high in cycle N+1.
  - mem_ack in cycle N+1 -> ack in cycle N+2, the minimum.
  - Peak throughput is 1 access per 3 cycles.
- mem_sel keeps its last value in IDLE; it changes only on a grant.
- Non-owner rdata keeps its previous value. i_ack and d_ack are never high together.
- mem_ack received in IDLE or RESP is ignored.
- A requester dropping req during BUSY is a protocol violation; the access completes and ack is still issued.
- Simultaneous i_req and d_req with streak<MAX_D_STREAK -> D wins.

Decomposition:
- Shared package mips_bus_pkg:
  - State encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2.
  - SEL_I=1'b0, SEL_D=1'b1.
- Sub-modules: the existing mux2_1 is instantiated for next-address selection before the capture register, with WIDTH=AW-1 so the mux is AW bits wide, and again for next-wdata selection with WIDTH=DW-1. No other sub-module is needed.

Test Plan:
- Only i_req=1 with i_addr=0x00400000, memory acks 1 cycle after mem_req -> mem_sel=0, mem_addr=0x00400000, mem_we=0; i_ack pulses 2 cycles after req sampled; i_rdata=mem_rdata (0x8C010004).
- i_req and d_req both high, d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF -> D served first with mem_we=1 and mem_wdata=0xDEADBEEF; I served immediately after.
- d_req held continuously and i_req held, MAX_D_STREAK=4 -> sequence of grants D,D,D,D,I,D,...; I is never starved beyond 4 D accesses.
- mem_ack never asserted, TIMEOUT=64 -> after 64 BUSY cycles the owner ack=1, bus_err=1, rdata=0x00000000; next cycle is IDLE.
- rst_n pulled low mid-BUSY -> mem_req=0 asynchronously; after release, no i_ack/d_ack, state IDLE, streak=0.
- mem_ack pulsed while IDLE -> no ack outputs and no state change.
